// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, instruction classes and funct constants shared by the decode stage and the ALU.
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_ctrl_e;
    typedef enum logic [1:0] {
        OP_LS = 2'b00,
        OP_BR = 2'b01,
        OP_R  = 2'b10,
        OP_I  = 2'b11
    } alu_op_e;
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_e;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    typedef struct packed {
        alu_ctrl_e   ctrl;
        logic        illegal;
        logic [63:0] op1;
        logic [63:0] op2;
    } entry_t;
endpackage

// File: rtl/alu_ctrl_stage_if.sv
// alu_ctrl_stage_if: decode-side input handshake and ALU-side output handshake of the control stage.
interface alu_ctrl_stage_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  alu_op_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [63:0] op1_i;
    logic [63:0] op2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  ctrl_signal_o;
    logic [63:0] op1_o;
    logic [63:0] op2_o;
    logic        illegal_o;
    modport slave (
        input  in_valid_i, alu_op_i, funct3_i, funct7_i, op1_i, op2_i, out_ready_i,
        output in_ready_o, out_valid_o, ctrl_signal_o, op1_o, op2_o, illegal_o
    );
    modport master (
        output in_valid_i, alu_op_i, funct3_i, funct7_i, op1_i, op2_i, out_ready_i,
        input  in_ready_o, out_valid_o, ctrl_signal_o, op1_o, op2_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: maps instruction class and funct fields to a 4-bit ALU control code.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_ctrl_e  ctrl_o,
    output logic       illegal_o
);
    always_comb begin
        ctrl_o    = ALU_ADD;
        illegal_o = 1'b0;
        case (alu_op_i)
            OP_LS: ctrl_o = ALU_ADD;
            OP_BR: ctrl_o = ALU_SUB;
            OP_R: begin
                case ({funct3_i, funct7_i})
                    {F3_ADD, F7_BASE}: ctrl_o = ALU_ADD;
                    {F3_ADD, F7_ALT}:  ctrl_o = ALU_SUB;
                    {F3_AND, F7_BASE}: ctrl_o = ALU_AND;
                    {F3_OR,  F7_BASE}: ctrl_o = ALU_OR;
                    default:           illegal_o = 1'b1;
                endcase
            end
            default: begin
                case (funct3_i)
                    F3_ADD:  ctrl_o = ALU_ADD;
                    F3_AND:  ctrl_o = ALU_AND;
                    F3_OR:   ctrl_o = ALU_OR;
                    default: illegal_o = 1'b1;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: decodes ALU control at the input and buffers operations in a 2-entry skid buffer
// so in_ready_o depends only on registered state.
module alu_ctrl_stage
    import alu_pkg::*;
(
    input logic clk_i,
    input logic rst_ni,
    input logic flush_i,
    alu_ctrl_stage_if.slave bus
);
    localparam entry_t RST_ENTRY = '{ctrl: ALU_ADD, illegal: 1'b0, op1: '0, op2: '0};
    alu_ctrl_e dec_ctrl;
    logic      dec_illegal;
    state_e    state_q, state_d;
    entry_t    main_q, main_d, skid_q, skid_d, in_entry;
    logic      accept, drain;
    alu_ctrl_decode u_dec (
        .alu_op_i  (bus.alu_op_i),
        .funct3_i  (bus.funct3_i),
        .funct7_i  (bus.funct7_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );
    assign in_entry          = '{ctrl: dec_ctrl, illegal: dec_illegal, op1: bus.op1_i, op2: bus.op2_i};
    assign bus.in_ready_o    = state_q != TWO;
    assign bus.out_valid_o   = state_q != EMPTY;
    assign bus.ctrl_signal_o = main_q.ctrl;
    assign bus.illegal_o     = main_q.illegal;
    assign bus.op1_o         = main_q.op1;
    assign bus.op2_o         = main_q.op2;
    assign accept            = bus.in_valid_i && bus.in_ready_o;
    assign drain             = bus.out_valid_o && bus.out_ready_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= RST_ENTRY;
            skid_q  <= RST_ENTRY;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
    // Flush only empties the buffer; payload registers keep their last value.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) state_d = EMPTY;
        else begin
            case (state_q)
                EMPTY: if (accept) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && !drain) begin
                        skid_d  = in_entry;
                        state_d = TWO;
                    end else if (accept) main_d = in_entry;
                    else if (drain) state_d = EMPTY;
                end
                TWO: if (drain) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 clk_i  input  1  sole clock, all state on rising edge.
REQ-002 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid_i  input  1  upstream (decode) presents an operation.
REQ-004 in_ready_o  output  1  stage can accept; registered, not combinationally dependent on out_ready_i.
REQ-005 alu_op_i  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
REQ-006 funct3_i  input  3  instruction funct3.
REQ-007 funct7_i  input  7  instruction funct7; used for R-type only.
REQ-008 op1_i, op2_i  input  64 each  operands, passed through unmodified.
REQ-009 flush_i  input  1  discard all held operations.
REQ-010 out_valid_o  output  1  ALU-side operation valid.
REQ-011 out_ready_i  input  1  ALU/EX side consumes operation.
REQ-012 ctrl_signal_o  output  4  ALU control code, drives ALU ctrl_signal_i.
REQ-013 op1_o, op2_o  output  64 each  operands aligned with ctrl_signal_o.
REQ-014 illegal_o  output  1  operation not encodable in the ALU; valid with out_valid_o.

Function
REQ-015 Codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110; no other code is ever emitted.
REQ-016 alu_op 00 SHALL map to ADD; alu_op 01 SHALL map to SUB; funct fields ignored for both.
REQ-017 alu_op 10: funct3 000/funct7 0000000 -> ADD; 000/0100000 -> SUB; 111/0000000 -> AND; 110/0000000 -> OR.
REQ-018 alu_op 11: funct3 000 -> ADD, 111 -> AND, 110 -> OR; funct7 ignored.
REQ-019 Any other combination SHALL set illegal_o=1 with ctrl_signal_o=ADD (0010); operands still passed.
REQ-020 Transfer in SHALL occur when in_valid_i & in_ready_o; transfer out when out_valid_o & out_ready_i.
REQ-021 Latency SHALL be exactly 1 cycle: operation accepted at edge N is presented at out_* after edge N when stage was empty.
REQ-022 Storage SHALL be a 2-entry skid buffer (main + skid); FSM states EMPTY, ONE, TWO.
REQ-023 EMPTY: accept -> ONE. ONE: accept & no drain -> TWO; drain & no accept -> EMPTY; both or neither -> ONE. TWO: drain -> ONE (skid moves to main); accept impossible.
REQ-024 in_ready_o SHALL be 1 in EMPTY and ONE, 0 in TWO.
REQ-025 Ordering SHALL be strict FIFO; out_* SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-026 flush_i SHALL take priority over any simultaneous accept or drain: next state EMPTY, out_valid_o=0 next cycle, input in that cycle discarded.
REQ-027 Decoding SHALL occur before storage (stored code, not raw funct fields).
REQ-028 Output registers not valid SHALL hold last value; consumers qualify with out_valid_o.

Reset
REQ-029 rst_ni low SHALL immediately force EMPTY, out_valid_o=0, in_ready_o=1, illegal_o=0, ctrl_signal_o=0010, op1_o=op2_o=0.
REQ-030 Reset mid-operation SHALL drop all held operations; first accept after deassertion behaves as from EMPTY.

Structure
REQ-031 Package alu_pkg SHALL hold alu_ctrl_e (4-bit codes), alu_op_e (2-bit classes), funct3/funct7 constants, shared with the ALU.
REQ-032 Combinational decode SHALL be sub-module alu_ctrl_decode (alu_op, funct3, funct7 -> ctrl, illegal); stage instantiates it once at the input.

Verification
REQ-033 Reset, then R-type funct3=000 funct7=0100000 op1=10 op2=3, out_ready_i=1 -> next cycle out_valid_o=1, ctrl=0110, op1_o=10, op2_o=3, illegal_o=0.
REQ-034 I-type funct3=100 (XORI) -> ctrl=0010, illegal_o=1; R-type funct3=111 funct7=0100000 -> illegal_o=1.
REQ-035 out_ready_i=0, issue ops A,B -> in_ready_o=0 after B; C held upstream; release -> A,B,C out in order, no loss or duplicate.
REQ-036 State TWO with flush_i=1 and in_valid_i=1 same cycle -> out_valid_o=0 next cycle, in_ready_o=1, input discarded.
REQ-037 rst_ni asserted asynchronously between edges while ONE -> out_valid_o=0 immediately, outputs at REQ-029 values.
REQ-038 Random stimulus with random out_ready_i backpressure: scoreboard matches decode table and order, out_* stable under stall.
